// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit for the RV32M M extension.
// Products use a shift-add loop and quotients use a restoring loop, each
// taking one iteration per clock over XLEN clocks. A sign-fix cycle
// follows the loop. Division by zero and signed division overflow skip
// the loop and complete through a one-cycle SPECIAL state instead.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] opA,
  input  logic [XLEN-1:0] opB,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_FIX     = 2'd2;
  localparam logic [1:0] S_SPECIAL = 2'd3;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_REM    = 3'b110;

  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

  // Two's-complement negation, wrapping modulo 2^XLEN.
  function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
    neg_x = ~v + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

  // Two's-complement negation of the double-width product.
  function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] v);
    neg_2x = ~v + {{(2*XLEN-1){1'b0}}, 1'b1};
  endfunction

  // Control state (reset) and datapath state (no reset)
  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [2:0]        fn_q, fn_d;
  logic [XLEN-1:0]   a_mag_q, a_mag_d;
  logic [XLEN-1:0]   b_mag_q, b_mag_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              neg_q, neg_d;

  // Operand decode at capture time
  logic              a_signed_in, b_signed_in, a_neg_in, b_neg_in;
  logic              is_div_in, div_zero_in, div_ovf_in;
  logic [XLEN-1:0]   a_mag_in, b_mag_in, special_res_in;

  // Iteration datapath
  logic [XLEN:0]     ml_sum;
  logic [2*XLEN-1:0] mul_step;
  logic [XLEN:0]     dv_part, dv_diff;
  logic [2*XLEN-1:0] div_step;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

  // Sign interpretation, magnitudes and early-exit detection of new operands.
  always_comb begin
    a_signed_in = (funct3 == F_MULH) || (funct3 == F_MULHSU) ||
                  (funct3 == F_DIV)  || (funct3 == F_REM);
    b_signed_in = (funct3 == F_MULH) || (funct3 == F_DIV) || (funct3 == F_REM);
    a_neg_in    = a_signed_in && opA[XLEN-1];
    b_neg_in    = b_signed_in && opB[XLEN-1];
    a_mag_in    = a_neg_in ? neg_x(opA) : opA;
    b_mag_in    = b_neg_in ? neg_x(opB) : opB;
    is_div_in   = funct3[2];
    div_zero_in = is_div_in && (opB == {XLEN{1'b0}});
    div_ovf_in  = ((funct3 == F_DIV) || (funct3 == F_REM)) &&
                  (opA == MIN_NEG) && (opB == ALL_ONES);
    // funct3[1] separates the remainder forms from the quotient forms
    if (div_zero_in) begin
      special_res_in = funct3[1] ? opA : ALL_ONES;
    end else begin
      special_res_in = funct3[1] ? {XLEN{1'b0}} : MIN_NEG;
    end
  end

  // One shift-add or restoring-division step on the shared accumulator.
  always_comb begin
    // Multiply: acc = {partial product, remaining multiplier bits}
    ml_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} +
               {1'b0, (acc_q[0] ? a_mag_q : {XLEN{1'b0}})};
    mul_step = {ml_sum, acc_q[XLEN-1:1]};
    // Divide: acc = {remainder, dividend bits shifting into quotient}
    dv_part  = acc_q[2*XLEN-1:XLEN-1];
    dv_diff  = dv_part - {1'b0, b_mag_q};
    if (dv_diff[XLEN]) begin
      div_step = {dv_part[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end else begin
      div_step = {dv_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end
  end

  // Sign correction and half/quotient/remainder selection after the loop.
  always_comb begin
    prod_fix = neg_q ? neg_2x(acc_q) : acc_q;
    quo_fix  = neg_q ? neg_x(acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
    rem_fix  = neg_q ? neg_x(acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];
    case (fn_q)
      F_MUL:          fix_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010,
      3'b011:         fix_res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101: fix_res = quo_fix;
      default:        fix_res = rem_fix;
    endcase
  end

  // Next-state logic for the IDLE/RUN/FIX/SPECIAL sequencer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    result_d = result_q;
    fn_d     = fn_q;
    a_mag_d  = a_mag_q;
    b_mag_d  = b_mag_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          fn_d    = funct3;
          a_mag_d = a_mag_in;
          b_mag_d = b_mag_in;
          cnt_d   = {CW{1'b0}};
          // Remainder takes the dividend sign; everything else the XOR
          neg_d   = funct3[2] && funct3[1] ? a_neg_in : (a_neg_in ^ b_neg_in);
          if (div_zero_in || div_ovf_in) begin
            state_d = S_SPECIAL;
            acc_d   = {{XLEN{1'b0}}, special_res_in};
          end else begin
            state_d = S_RUN;
            acc_d   = {{XLEN{1'b0}}, (is_div_in ? a_mag_in : b_mag_in)};
          end
        end
      end
      S_RUN: begin
        acc_d = fn_q[2] ? div_step : mul_step;
        if (cnt_q == CW'(XLEN-1)) begin
          state_d = S_FIX;
          cnt_d   = {CW{1'b0}};
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_FIX: begin
        result_d = fix_res;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      S_SPECIAL: begin
        result_d = acc_q[XLEN-1:0];
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers; reset aborts any operation in flight.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CW{1'b0}};
      done_q   <= 1'b0;
      result_q <= {XLEN{1'b0}};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  // Datapath registers; only meaningful while the sequencer is active.
  always_ff @(posedge Clock) begin
    fn_q    <= fn_d;
    a_mag_q <= a_mag_d;
    b_mag_q <= b_mag_d;
    acc_q   <= acc_d;
    neg_q   <= neg_d;
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: vector table through a result scoreboard,
// plus hand-written handshake and reset-abort sequences.
module tb_muldiv_unit;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] opA, opB;
  logic        busy, done;
  logic [31:0] result;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          t_start  = 0;
  logic [31:0] sb_q[$];
  string       nm_q[$];
  vec_t        vecs[$];

  muldiv_unit #(.XLEN(32)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .start (start),
    .funct3(funct3),
    .opA   (opA),
    .opB   (opB),
    .busy  (busy),
    .done  (done),
    .result(result)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation
  always @(negedge Clock) begin
    if (Reset === 1'b0 && done === 1'b1) begin
      if (sb_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else chk(nm_q.pop_front(), result, sb_q.pop_front());
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string nm, input bit expect_done);
    funct3 = f;
    opA    = a;
    opB    = b;
    start  = 1'b1;
    if (expect_done) begin
      sb_q.push_back(exp);
      nm_q.push_back(nm);
    end
    @(posedge Clock);
    #1;
    start   = 1'b0;
    t_start = cyc;
  endtask

  task automatic wait_done(input string nm, input int exp_lat);
    int lat;
    lat = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge Clock);
      if (done === 1'b1) begin
        lat = cyc - t_start;
        break;
      end
    end
    chk({nm, "_latency"}, lat, exp_lat);
  endtask

  initial begin
    int seen;
    vecs.push_back('{3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, "mul_7xm3"});
    vecs.push_back('{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, "mulhu_max"});
    vecs.push_back('{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33, "mulh_minmin"});
    vecs.push_back('{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, "mulhsu_m1"});
    vecs.push_back('{3'b010, 32'h00000002, 32'hFFFFFFFF, 32'h00000001, 33, "mulhsu_pos"});
    vecs.push_back('{3'b001, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 33, "mulh_m3x5"});
    vecs.push_back('{3'b000, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFF1, 33, "mul_m3x5"});
    vecs.push_back('{3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33, "div_m7_2"});
    vecs.push_back('{3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33, "rem_m7_2"});
    vecs.push_back('{3'b101, 32'd100,      32'd7,        32'd14,       33, "divu_100_7"});
    vecs.push_back('{3'b111, 32'd100,      32'd7,        32'd2,        33, "remu_100_7"});
    vecs.push_back('{3'b100, 32'd20,       32'hFFFFFFFD, 32'hFFFFFFFA, 33, "div_20_m3"});
    vecs.push_back('{3'b110, 32'd20,       32'hFFFFFFFD, 32'h00000002, 33, "rem_20_m3"});
    vecs.push_back('{3'b100, 32'h80000000, 32'd3,        32'hD5555556, 33, "div_min_3"});
    vecs.push_back('{3'b110, 32'h80000000, 32'd3,        32'hFFFFFFFE, 33, "rem_min_3"});
    vecs.push_back('{3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  "divu_by0"});
    vecs.push_back('{3'b111, 32'd5,        32'd0,        32'h00000005, 1,  "remu_by0"});
    vecs.push_back('{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  "div_ovf"});
    vecs.push_back('{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1,  "rem_ovf"});
    vecs.push_back('{3'b100, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 1,  "div_by0"});
    vecs.push_back('{3'b110, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1,  "rem_by0"});

    Reset  = 1'b1;
    start  = 1'b0;
    funct3 = 3'b000;
    opA    = 32'd0;
    opB    = 32'd0;
    repeat (3) @(posedge Clock);
    #1;
    chk("reset_busy",   {31'd0, busy}, 32'd0);
    chk("reset_done",   {31'd0, done}, 32'd0);
    chk("reset_result", result,        32'd0);
    @(negedge Clock);
    Reset = 1'b0;

    // Table-driven operations
    foreach (vecs[i]) begin
      launch(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name, 1'b1);
      chk({vecs[i].name, "_busy"}, {31'd0, busy}, 32'd1);
      wait_done(vecs[i].name, vecs[i].lat);
      @(negedge Clock);
      chk({vecs[i].name, "_done_pulse"}, {31'd0, done}, 32'd0);
      chk({vecs[i].name, "_idle"},       {31'd0, busy}, 32'd0);
    end

    // start while busy is ignored; the first operation's result is returned
    launch(3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, "ignore_mul", 1'b1);
    repeat (4) @(negedge Clock);
    funct3 = 3'b011;
    opA    = 32'h12345678;
    opB    = 32'h00000009;
    start  = 1'b1;
    @(posedge Clock);
    #1;
    start = 1'b0;
    chk("ignore_busy", {31'd0, busy}, 32'd1);
    wait_done("ignore_mul", 33);
    @(negedge Clock);
    chk("ignore_no_second", {31'd0, busy}, 32'd0);

    // start in the done cycle is accepted with no dead cycle
    launch(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "b2b_first", 1'b1);
    wait_done("b2b_first", 33);
    launch(3'b101, 32'd100, 32'd7, 32'd14, "b2b_second", 1'b1);
    wait_done("b2b_second", 33);
    @(negedge Clock);

    // Reset during a divide aborts it without a done pulse
    launch(3'b100, 32'd1000, 32'd3, 32'd0, "aborted_div", 1'b0);
    repeat (8) @(negedge Clock);
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    chk("abort_busy",   {31'd0, busy}, 32'd0);
    chk("abort_result", result,        32'd0);
    chk("abort_done",   {31'd0, done}, 32'd0);
    @(negedge Clock);
    Reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clock);
      if (done === 1'b1) seen++;
    end
    chk("abort_no_done", seen, 32'd0);
    launch(3'b111, 32'd100, 32'd7, 32'd2, "after_abort_remu", 1'b1);
    wait_done("after_abort_remu", 33);
    @(negedge Clock);

    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
